// File: rtl/fu_add_seq.sv
// Sequential N-byte adder/subtractor that reuses one 8-bit carry-select slice,
// one byte per cycle LSB first, with valid/ready on both request and result.

module fu_csa8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       c_i,
    output logic [7:0] s_o,
    output logic       c_o
);
    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    // Upper nibble is computed for both possible carries, then selected by the low carry.
    always_comb begin
        lo  = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0, c_i};
        hi0 = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]};
        hi1 = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + 5'd1;
        s_o = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
        c_o = lo[4] ? hi1[4] : hi0[4];
    end
endmodule

module fu_add_seq #(
    parameter int N_SLICE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*N_SLICE-1:0] din1,
    input  logic [8*N_SLICE-1:0] din2,
    input  logic                 carry_in,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*N_SLICE-1:0] dout,
    output logic                 carry_out,
    output logic                 overflow
);
    localparam int W     = 8 * N_SLICE;
    localparam int IDX_W = $clog2(N_SLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     dout_q;
    logic             c_q;
    logic             carry_q;
    logic             ovf_q;

    logic [7:0]       slice_a;
    logic [7:0]       slice_b;
    logic [7:0]       slice_s;
    logic             slice_c;
    logic             ovf_d;

    assign slice_a = a_q[8*idx_q +: 8];
    assign slice_b = b_q[8*idx_q +: 8];

    fu_csa8 u_slice (
        .a_i (slice_a),
        .b_i (slice_b),
        .c_i (c_q),
        .s_o (slice_s),
        .c_o (slice_c)
    );

    // b_q already holds ~B for subtract, so one rule covers both operations.
    assign ovf_d = (a_q[W-1] == b_q[W-1]) && (slice_s[7] != a_q[W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are cleared too, so dout reads zero right after reset.
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            dout_q  <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= din1;
                        b_q     <= sub ? ~din2 : din2;
                        c_q     <= sub | carry_in;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    dout_q[8*idx_q +: 8] <= slice_s;
                    c_q                  <= slice_c;
                    if (idx_q == LAST_IDX) begin
                        carry_q <= slice_c;
                        ovf_q   <= ovf_d;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dout      = dout_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_fu_add_seq.sv
// Self-checking bench for fu_add_seq (N_SLICE=4): directed cases, random ops
// against an arithmetic model, backpressure, mid-op reset and back-to-back.

module tb_fu_add_seq;
    localparam int N = 4;
    localparam int W = 8 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] din1 = '0;
    logic [W-1:0] din2 = '0;
    logic         carry_in = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] dout;
    logic         carry_out;
    logic         overflow;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        s;
        logic [31:0] r;
        logic        co;
        logic        ov;
    } vec_t;

    fu_add_seq #(.N_SLICE(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din1      (din1),
        .din2      (din2),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference: plain wide arithmetic; subtract carry means "no borrow" (A >= B).
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic s,
                                  output logic [31:0] r, output logic co, output logic ov);
        logic [32:0] full;
        if (s) begin
            full = {1'b0, a} - {1'b0, b};
            r    = full[31:0];
            co   = (a >= b);
            ov   = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {32'b0, cin};
            r    = full[31:0];
            co   = full[32];
            ov   = (a[31] == b[31]) && (r[31] != a[31]);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, scrambles ignored inputs while busy, returns the
    // result seen in DONE and the cycle count from accept to out_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic s,
                          output logic [31:0] d, output logic co, output logic ov,
                          output int lat);
        int guard;
        guard     = 0;
        out_ready = 1'b0;
        din1      = a;
        din2      = b;
        carry_in  = cin;
        sub       = s;
        in_valid  = 1'b1;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        step();
        in_valid = 1'b0;
        din1     = $urandom;
        din2     = $urandom;
        carry_in = 1'($urandom);
        sub      = 1'($urandom);
        lat      = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        d         = dout;
        co        = carry_out;
        ov        = overflow;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (dout !== '0) $display("FAIL reset_dout got %h exp 0", dout); else n_pass++;
        n_checks++; if (carry_out !== 1'b0) $display("FAIL reset_carry got %b exp 0", carry_out); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else n_pass++;
    endtask

    task automatic test_directed();
        vec_t        v[7];
        logic [31:0] d;
        logic        co, ov;
        int          lat;
        v[0] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
        v[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        v[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        v[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        v[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        v[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        v[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            run_op(v[i].a, v[i].b, v[i].cin, v[i].s, d, co, ov, lat);
            n_checks++; if (lat !== N) $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, N); else n_pass++;
            n_checks++; if (d !== v[i].r) $display("FAIL dir%0d_dout got %h exp %h", i, d, v[i].r); else n_pass++;
            n_checks++; if (co !== v[i].co) $display("FAIL dir%0d_carry got %b exp %b", i, co, v[i].co); else n_pass++;
            n_checks++; if (ov !== v[i].ov) $display("FAIL dir%0d_overflow got %b exp %b", i, ov, v[i].ov); else n_pass++;
            n_checks++; if (in_ready !== 1'b1) $display("FAIL dir%0d_ready_after got %b exp 1", i, in_ready); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, d, er;
        logic        cin, s, co, ov, eco, eov;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom);
            s   = 1'($urandom);
            model(a, b, cin, s, er, eco, eov);
            run_op(a, b, cin, s, d, co, ov, lat);
            n_checks++; if (lat !== N) $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, N); else n_pass++;
            n_checks++; if (d !== er) $display("FAIL rnd%0d_dout a=%h b=%h s=%b got %h exp %h", i, a, b, s, d, er); else n_pass++;
            n_checks++; if (co !== eco) $display("FAIL rnd%0d_carry got %b exp %b", i, co, eco); else n_pass++;
            n_checks++; if (ov !== eov) $display("FAIL rnd%0d_overflow got %b exp %b", i, ov, eov); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] er;
        logic        eco, eov;
        int          lat;
        bit          extra_valid;
        model(32'h7FFF_FF00, 32'h0000_0100, 1'b0, 1'b0, er, eco, eov);
        din1      = 32'h7FFF_FF00;
        din2      = 32'h0000_0100;
        carry_in  = 1'b0;
        sub       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_idle_ready got %b exp 1", in_ready); else n_pass++;
        step();
        lat = 0;
        while (!out_valid && lat < 50) begin
            in_valid  = ~in_valid;
            out_ready = ~out_ready;
            din1      = $urandom;
            din2      = $urandom;
            sub       = 1'($urandom);
            step();
            lat++;
        end
        out_ready = 1'b0;
        n_checks++; if (lat !== N) $display("FAIL bp_latency got %0d exp %0d", lat, N); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold%0d_valid got %b exp 1", c, out_valid); else n_pass++;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_hold%0d_ready got %b exp 0", c, in_ready); else n_pass++;
            n_checks++; if (dout !== er) $display("FAIL bp_hold%0d_dout got %h exp %h", c, dout, er); else n_pass++;
            n_checks++; if ({carry_out, overflow} !== {eco, eov}) $display("FAIL bp_hold%0d_flags got %b%b exp %b%b", c, carry_out, overflow, eco, eov); else n_pass++;
            in_valid = ~in_valid;
            din1     = $urandom;
            din2     = $urandom;
            step();
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got %b exp 0", out_valid); else n_pass++;
        extra_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid || !in_ready) extra_valid = 1'b1;
        end
        n_checks++; if (extra_valid !== 1'b0) $display("FAIL bp_second_accept got %b exp 0", extra_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        co, ov;
        int          lat;
        bit          seen_valid;
        din1      = 32'hFFFF_FFFF;
        din2      = 32'hFFFF_FFFF;
        carry_in  = 1'b1;
        sub       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready got %b exp 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (dout !== '0) $display("FAIL rstmid_dout got %h exp 0", dout); else n_pass++;
        seen_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid) seen_valid = 1'b1;
        end
        n_checks++; if (seen_valid !== 1'b0) $display("FAIL rstmid_no_pulse got %b exp 0", seen_valid); else n_pass++;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, d, co, ov, lat);
        n_checks++; if (d !== 32'h2345_6789) $display("FAIL rstmid_after_dout got %h exp 23456789", d); else n_pass++;
        n_checks++; if (co !== 1'b0) $display("FAIL rstmid_after_carry got %b exp 0", co); else n_pass++;
        n_checks++; if (lat !== N) $display("FAIL rstmid_after_latency got %0d exp %0d", lat, N); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops_a[2];
        logic [31:0] ops_b[2];
        logic [31:0] res[$];
        logic [31:0] er;
        logic        eco, eov;
        int          acc[$];
        int          c;
        ops_a[0] = $urandom;
        ops_b[0] = $urandom;
        ops_a[1] = $urandom;
        ops_b[1] = $urandom;
        din1      = ops_a[0];
        din2      = ops_b[0];
        carry_in  = 1'b0;
        sub       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        c = 0;
        while (res.size() < 2 && c < 60) begin
            if (in_valid && in_ready) acc.push_back(c);
            if (out_valid) res.push_back(dout);
            step();
            c++;
            if (acc.size() == 1) begin
                din1 = ops_a[1];
                din2 = ops_b[1];
            end else if (acc.size() >= 2) begin
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_checks++; if (acc.size() !== 2) $display("FAIL b2b_accepts got %0d exp 2", acc.size()); else n_pass++;
        n_checks++; if (res.size() !== 2) $display("FAIL b2b_results got %0d exp 2", res.size()); else n_pass++;
        if (acc.size() == 2) begin
            n_checks++; if (acc[1] - acc[0] !== N + 2) $display("FAIL b2b_spacing got %0d exp %0d", acc[1] - acc[0], N + 2); else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            if (i < res.size()) begin
                model(ops_a[i], ops_b[i], 1'b0, 1'b0, er, eco, eov);
                n_checks++; if (res[i] !== er) $display("FAIL b2b_res%0d got %h exp %h", i, res[i], er); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
